// File: rtl/turnstile_credit_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : turnstile_credit_arbiter
// Purpose  : Shared coin-credit pool with round-robin passage arbitration for
//            N_GATES turnstiles. Define TCA_TIMEOUT_EN to add a PASSING timeout.
// Revision : 1.0
// =============================================================================
module turnstile_credit_arbiter #(
   parameter int unsigned N_GATES     = 4,
   parameter int unsigned CREDIT_W    = 8,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_GATES-1:0]  coin_i,
   input  logic [N_GATES-1:0]  push_i,
   output logic [N_GATES-1:0]  grant_o,
   output logic [N_GATES-1:0]  passing_o,
   output logic                unlocked_o,
   output logic [CREDIT_W-1:0] credit_o,
   output logic [15:0]         pass_cnt_o,
   output logic                overflow_o,
   output logic [N_GATES-1:0]  timeout_o
);

   localparam int unsigned    PTR_W      = $clog2(N_GATES);
   localparam int unsigned    SUM_W      = CREDIT_W + 4;
   localparam logic [SUM_W-1:0] CREDIT_MAX = {4'b0000, {CREDIT_W{1'b1}}};

   typedef enum logic [0:0] {
      GATE_IDLE    = 1'b0,
      GATE_PASSING = 1'b1
   } gate_state_e;

   if (N_GATES < 2 || N_GATES > 8 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("turnstile_credit_arbiter: unsupported parameter set");
   end

   gate_state_e         state_q [N_GATES];
   gate_state_e         state_d [N_GATES];
   logic [N_GATES-1:0]  grant_q, grant_d;
   logic [PTR_W-1:0]    rr_q, rr_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [15:0]         pass_cnt_q, pass_cnt_d;
   logic                overflow_q, overflow_d;

   logic [N_GATES-1:0]  eligible;
   logic                found;
   logic [PTR_W-1:0]    sel;
   logic [PTR_W:0]      idx;
   logic [3:0]          coin_cnt;
   logic [SUM_W-1:0]    credit_sum;

`ifdef TCA_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]    cnt_q [N_GATES];
   logic [CNT_W-1:0]    cnt_d [N_GATES];
   logic [N_GATES-1:0]  blocked_q, blocked_d;
   logic [N_GATES-1:0]  timeout_q, timeout_d;
`endif

   always_comb begin
      for (int g = 0; g < N_GATES; g++) begin
         eligible[g] = push_i[g] && (state_q[g] == GATE_IDLE) && !grant_q[g];
`ifdef TCA_TIMEOUT_EN
         // A timed-out gate waits for push_i to fall before it may compete again.
         eligible[g] = eligible[g] && !blocked_q[g];
`endif
      end
   end

   // Round-robin search starting at rr_q, wrapping at N_GATES.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = 0; i < N_GATES; i++) begin
         idx = {1'b0, rr_q} + (PTR_W+1)'(i);
         if (idx >= (PTR_W+1)'(N_GATES)) begin
            idx = idx - (PTR_W+1)'(N_GATES);
         end
         if (!found && eligible[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            sel   = idx[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      grant_d    = '0;
      rr_d       = rr_q;
      pass_cnt_d = pass_cnt_q;
      overflow_d = overflow_q;
      coin_cnt   = '0;

      if (found && (credit_q != '0)) begin
         grant_d[sel] = 1'b1;
         rr_d         = (sel == PTR_W'(N_GATES - 1)) ? '0 : sel + 1'b1;
         pass_cnt_d   = pass_cnt_q + 16'd1;
      end

      for (int g = 0; g < N_GATES; g++) begin
         coin_cnt = coin_cnt + {3'b000, coin_i[g]};
      end

      // Coins added and grant debited before saturating.
      credit_sum = {4'b0000, credit_q} + SUM_W'(coin_cnt) - SUM_W'(|grant_d);
      if (credit_sum > CREDIT_MAX) begin
         credit_d   = '1;
         overflow_d = 1'b1;
      end else begin
         credit_d   = credit_sum[CREDIT_W-1:0];
      end
   end

   always_comb begin
      for (int g = 0; g < N_GATES; g++) begin
         state_d[g] = state_q[g];
`ifdef TCA_TIMEOUT_EN
         cnt_d[g]     = cnt_q[g];
         timeout_d[g] = 1'b0;
         blocked_d[g] = blocked_q[g] & push_i[g];
`endif
         case (state_q[g])
            GATE_IDLE: begin
               if (grant_d[g]) begin
                  state_d[g] = GATE_PASSING;
`ifdef TCA_TIMEOUT_EN
                  cnt_d[g]   = '0;
`endif
               end
            end
            GATE_PASSING: begin
               if (!push_i[g]) begin
                  state_d[g] = GATE_IDLE;
               end
`ifdef TCA_TIMEOUT_EN
               else if (cnt_q[g] == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state_d[g]   = GATE_IDLE;
                  timeout_d[g] = 1'b1;
                  blocked_d[g] = 1'b1;
               end else begin
                  cnt_d[g]     = cnt_q[g] + 1'b1;
               end
`endif
            end
            default: state_d[g] = GATE_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int g = 0; g < N_GATES; g++) begin
            state_q[g] <= GATE_IDLE;
         end
         grant_q    <= '0;
         rr_q       <= '0;
         credit_q   <= '0;
         pass_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int g = 0; g < N_GATES; g++) begin
            state_q[g] <= state_d[g];
         end
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         credit_q   <= credit_d;
         pass_cnt_q <= pass_cnt_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef TCA_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int g = 0; g < N_GATES; g++) begin
            cnt_q[g] <= '0;
         end
         blocked_q <= '0;
         timeout_q <= '0;
      end else begin
         for (int g = 0; g < N_GATES; g++) begin
            cnt_q[g] <= cnt_d[g];
         end
         blocked_q <= blocked_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_o = '0;
`endif

   always_comb begin
      for (int g = 0; g < N_GATES; g++) begin
         passing_o[g] = (state_q[g] == GATE_PASSING);
      end
   end

   assign grant_o    = grant_q;
   assign credit_o   = credit_q;
   assign unlocked_o = (credit_q != '0);
   assign pass_cnt_o = pass_cnt_q;
   assign overflow_o = overflow_q;

endmodule
`default_nettype wire
